layer_serializer: RTL

LAYER_SERIALIZER -- requirements
Module: layer_serializer

---
 rtl/layer_serializer_pkg.sv | 24 ++
 rtl/layer_serializer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/layer_serializer_pkg.sv
// Shared network parameters for the layer serializer: neuron/word defaults,
// FSM state encoding and a counter-width helper.
package layer_serializer_pkg;

  // Network-wide defaults
  localparam int DEFAULT_NUM_NEURONS = 30;
  localparam int DEFAULT_DATAWIDTH   = 16;
  localparam int DEFAULT_MIN_GAP     = 6;

  // Serializer FSM encoding (kept as plain constants for legacy tooling)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/layer_serializer.sv
// Converts one parallel layer output vector into a serial word stream for the
// next layer. One vector may wait in a pending slot while another streams;
// a vector arriving with the slot occupied is dropped and flagged sticky.
// Consecutive streams are separated by at least MIN_GAP idle cycles.
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int DATAWIDTH   = DEFAULT_DATAWIDTH,
  parameter int MIN_GAP     = DEFAULT_MIN_GAP
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_NEURONS*DATAWIDTH-1:0] in_data,
  input  logic                             in_valid,
  output logic [DATAWIDTH-1:0]             out_data,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             overflow
);

  localparam int VW = NUM_NEURONS * DATAWIDTH;
  localparam int CW = cnt_width(NUM_NEURONS);
  localparam int GW = cnt_width(MIN_GAP + 1);

  logic [1:0]           state_r,     state_s;
  logic [VW-1:0]        shift_r,     shift_s;
  logic [VW-1:0]        pend_data_r, pend_data_s;
  logic                 pend_full_r, pend_full_s;
  logic [CW-1:0]        word_cnt_r,  word_cnt_s;
  logic [GW-1:0]        gap_cnt_r,   gap_cnt_s;
  logic [DATAWIDTH-1:0] out_data_s;
  logic                 out_valid_s;
  logic                 busy_s;
  logic                 overflow_s;
  logic                 ending_s;
  logic                 load_en_s;
  logic [VW-1:0]        load_vec_s;

  // Next-state logic: stream progression, gap timing, pending slot and loads
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    pend_data_s = pend_data_r;
    pend_full_s = pend_full_r;
    word_cnt_s  = word_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    out_data_s  = {DATAWIDTH{1'b0}};
    out_valid_s = 1'b0;
    overflow_s  = overflow;
    ending_s    = 1'b0;
    load_en_s   = 1'b0;
    load_vec_s  = {VW{1'b0}};

    case (state_r)
      ST_IDLE: begin
        state_s = ST_IDLE;
      end
      ST_SEND: begin
        if (word_cnt_r == CW'(NUM_NEURONS - 1)) begin
          // With no gap required the vector boundary happens right here
          if (MIN_GAP == 0) begin
            ending_s = 1'b1;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = {GW{1'b0}};
          end
        end else begin
          out_valid_s = 1'b1;
          out_data_s  = shift_r[DATAWIDTH-1:0];
          shift_s     = shift_r >> DATAWIDTH;
          word_cnt_s  = word_cnt_r + CW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GW'(MIN_GAP - 1)) begin
          ending_s = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Vector boundary: promote the pending vector or fall back to idle
    if (ending_s) begin
      if (pend_full_r) begin
        load_en_s   = 1'b1;
        load_vec_s  = pend_data_r;
        pend_full_s = 1'b0;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      ending_s = 1'b0;
    end

    // New vector: stream it, park it, or drop it; a slot freed this cycle is reusable
    if (in_valid) begin
      if ((state_r == ST_IDLE) || (ending_s && !pend_full_r)) begin
        load_en_s  = 1'b1;
        load_vec_s = in_data;
      end else if (!pend_full_s) begin
        pend_data_s = in_data;
        pend_full_s = 1'b1;
      end else begin
        overflow_s = 1'b1;
      end
    end else begin
      overflow_s = overflow_s;
    end

    // Loading emits word 0 immediately and keeps the rest in the shifter
    if (load_en_s) begin
      state_s     = ST_SEND;
      out_valid_s = 1'b1;
      out_data_s  = load_vec_s[DATAWIDTH-1:0];
      shift_s     = load_vec_s >> DATAWIDTH;
      word_cnt_s  = {CW{1'b0}};
      gap_cnt_s   = {GW{1'b0}};
    end else begin
      load_vec_s = load_vec_s;
    end

    busy_s = (state_s != ST_IDLE) || pend_full_s;
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      shift_r     <= {VW{1'b0}};
      pend_data_r <= {VW{1'b0}};
      pend_full_r <= 1'b0;
      word_cnt_r  <= {CW{1'b0}};
      gap_cnt_r   <= {GW{1'b0}};
      out_data    <= {DATAWIDTH{1'b0}};
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      pend_data_r <= pend_data_s;
      pend_full_r <= pend_full_s;
      word_cnt_r  <= word_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      out_data    <= out_data_s;
      out_valid   <= out_valid_s;
      busy        <= busy_s;
      overflow    <= overflow_s;
    end
  end

endmodule
